// File: rtl/sensor_cond_pkg.sv
// Shared types and constants for the sensor conditioner: FSM state encoding and glitch counter width.
package sensor_cond_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor pin in, conditioned level/edge pulses and diagnostic glitch count out.
interface sensor_conditioner_if;
    import sensor_cond_pkg::*;

    logic                sensor;
    logic                sensor_clean;
    logic                sensor_rise;
    logic                sensor_fall;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        input  sensor,
        output sensor_clean, sensor_rise, sensor_fall, glitch_cnt
    );

    modport slave (
        output sensor,
        input  sensor_clean, sensor_rise, sensor_fall, glitch_cnt
    );
endinterface

// File: rtl/sensor_conditioner_sync.sv
// One-bit two-flop synchronizer for an asynchronous pin; 2 cycles latency, no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/sensor_conditioner.sv
// Synchronize + debounce a raw sensor pin; clean level and rise/fall pulses DEBOUNCE_CYCLES+1 edges after s1 samples the change.
// No backpressure. SENSOR_GLITCH_CNT_EN builds the saturating glitch counter, otherwise glitch_cnt reads 0.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    sensor_conditioner_if.master bus
);
    import sensor_cond_pkg::*;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s2;
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       clean, rise, fall;
    logic       clean_nxt, rise_nxt, fall_nxt;
    logic       glitch;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.sensor),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE_LOW;
            cnt   <= 8'd0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        glitch    = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nxt = QUAL_HIGH;
                    cnt_nxt   = 8'd1;
                end
            end
            QUAL_HIGH: begin
                if (!s2) begin
                    state_nxt = IDLE_LOW;
                    glitch    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            STABLE_HIGH: begin
                if (!s2) begin
                    state_nxt = QUAL_LOW;
                    cnt_nxt   = 8'd1;
                end
            end
            QUAL_LOW: begin
                if (s2) begin
                    state_nxt = STABLE_HIGH;
                    glitch    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE_LOW;
        endcase
        // Level follows the state being entered so it lines up with the rise/fall pulse.
        clean_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == QUAL_LOW);
    end

    assign bus.sensor_clean = clean;
    assign bus.sensor_rise  = rise;
    assign bus.sensor_fall  = fall;

`ifdef SENSOR_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            glitch_q <= '0;
        end else if (glitch) begin
            glitch_q <= sat_inc(glitch_q);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    logic glitch_unused;
    assign glitch_unused  = glitch;
    assign bus.glitch_cnt = '0;
`endif
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomized + directed bench for sensor_conditioner against a run-length reference model.
module tb_sensor_conditioner;
    import sensor_cond_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sensor_conditioner_if bus ();

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FSM acts on the pin value sampled two edges earlier; a level
    // change is accepted after DEB consecutive differing samples, a shorter run is a glitch.
    bit h1, h2;
    bit m_clean, m_rise, m_fall;
    int m_run, m_glitch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit seen;
        if (!rst) begin
            h1 = 0; h2 = 0;
            m_clean = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_glitch = 0;
        end else begin
            seen = h2;
            h2   = h1;
            h1   = bus.sensor;
            m_rise = 0;
            m_fall = 0;
            if (seen != m_clean) begin
                m_run++;
                if (m_run == DEB) begin
                    m_clean = ~m_clean;
                    if (m_clean) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
    endtask

    function automatic int exp_glitch();
`ifdef SENSOR_GLITCH_CNT_EN
        return m_glitch;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs();
        check_eq("clean",  bus.sensor_clean, m_clean);
        check_eq("rise",   bus.sensor_rise,  m_rise);
        check_eq("fall",   bus.sensor_fall,  m_fall);
        check_eq("glitch", bus.glitch_cnt,   exp_glitch());
    endtask

    // Called at a negedge: drive, step the model at the posedge, check at the next negedge.
    task automatic cycle(input logic s, input logic r);
        bus.sensor = s;
        rst        = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) cycle(s, 1'b1);
    endtask

    // Counts edges from the first one that samples sensor=1 until sensor_rise shows.
    task automatic measure_rise(input string tag);
        int n = 0;
        bit got = 0;
        while (!got && n < 40) begin
            cycle(1'b1, 1'b1);
            n++;
            if (bus.sensor_rise) got = 1;
        end
        check_eq(tag, n, DEB + 2);
        check_eq({tag, "_clean"}, bus.sensor_clean, 1);
    endtask

    initial begin
        int lvl, len;
        rst        = 1'b0;
        bus.sensor = 1'b0;
        @(negedge clk);

        // Reset held with the pin high, then latency from release.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check_eq("rst_glitch", bus.glitch_cnt, 0);
        measure_rise("rst_lat");

        // Dip in QUAL_LOW, then a real fall.
        hold(1'b1, 4);
        hold(1'b0, 2);
        hold(1'b1, 8);
        check_eq("dip_clean", bus.sensor_clean, 1);
        hold(1'b0, 12);
        check_eq("fall_clean", bus.sensor_clean, 0);

        // Short high pulse is rejected.
        hold(1'b1, 2);
        hold(1'b0, 8);
        check_eq("rej_clean", bus.sensor_clean, 0);

        // Clean rise from a settled low.
        measure_rise("rise_lat");
        hold(1'b1, 4);
        hold(1'b0, 12);

        // Reset in the middle of a qualification discards progress.
        hold(1'b1, 3);
        cycle(1'b1, 1'b0);
        measure_rise("midrst_lat");
        hold(1'b0, 12);

        // Random run lengths around the debounce window, occasional resets.
        for (int i = 0; i < 200; i++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 2 * DEB + 2));
            for (int j = 0; j < len; j++)
                cycle(lvl[0], ($urandom_range(0, 199) != 0));
        end

        // Saturation: start clean, then 300 aborted high qualifications.
        cycle(1'b0, 1'b0);
        hold(1'b0, 4);
        for (int i = 0; i < 300; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 4);
        end
        hold(1'b0, 10);
`ifdef SENSOR_GLITCH_CNT_EN
        check_eq("sat", bus.glitch_cnt, 255);
`else
        check_eq("sat", bus.glitch_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
